// File: rtl/mac_fifo_array_if.sv
// Write/start/result bundle between the board logic (master) and mac_fifo_array (slave).
interface mac_fifo_array_if #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                    wr_en;
  logic [CH_W-1:0]         wr_ch;
  logic [DATA_W-1:0]       a_in;
  logic [DATA_W-1:0]       b_in;
  logic                    wr_b_only;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [N_CH-1:0]         mismatch;
  logic [N_CH-1:0]         sat;
  logic [N_CH*ACC_W-1:0]   acc_out;

  modport master (
    output wr_en, wr_ch, a_in, b_in, wr_b_only, start,
    input  busy, done, err, mismatch, sat, acc_out
  );

  modport slave (
    input  wr_en, wr_ch, a_in, b_in, wr_b_only, start,
    output busy, done, err, mismatch, sat, acc_out
  );
endinterface

// File: rtl/mac_fifo_array.sv
// N_CH first-word-fall-through A/B FIFO pairs feeding 2-stage MACs; define MAC_SAT_EN to clamp instead of wrap.
// done pulses K+1 cycles after start (K = deepest pair count); writes only in IDLE, dropped writes set sticky err.
module mac_fifo_array #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ACC_W  = 24
) (
  input logic            clk,
  input logic            rst,
  mac_fifo_array_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                state;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [N_CH-1:0]       mismatch_q;

  logic [DATA_W-1:0]     mem_a [N_CH][DEPTH];
  logic [DATA_W-1:0]     mem_b [N_CH][DEPTH];
  logic [PW-1:0]         wp_a [N_CH];
  logic [PW-1:0]         rp_a [N_CH];
  logic [PW-1:0]         wp_b [N_CH];
  logic [PW-1:0]         rp_b [N_CH];
  logic [CW-1:0]         cnt_a [N_CH];
  logic [CW-1:0]         cnt_b [N_CH];

  logic [2*DATA_W-1:0]   prod [N_CH];
  logic [N_CH-1:0]       prod_vld;
  logic [ACC_W-1:0]      acc [N_CH];
  logic [ACC_W-1:0]      nxt_acc [N_CH];

  logic [N_CH-1:0]       sel;
  logic [N_CH-1:0]       push_a;
  logic [N_CH-1:0]       push_b;
  logic [N_CH-1:0]       pop;
  logic [N_CH-1:0]       full_hit;
  logic [DATA_W-1:0]     head_a [N_CH];
  logic [DATA_W-1:0]     head_b [N_CH];
  logic                  wr_fault;

`ifdef MAC_SAT_EN
  logic [ACC_W:0]        sum [N_CH];
  logic [N_CH-1:0]       sat_q;
`endif

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      sel[c]      = bus.wr_en && (state == IDLE) && (32'(bus.wr_ch) == c);
      push_b[c]   = sel[c] && (cnt_b[c] != CW'(DEPTH));
      push_a[c]   = sel[c] && !bus.wr_b_only && (cnt_a[c] != CW'(DEPTH));
      full_hit[c] = sel[c] && !(push_b[c] && (push_a[c] || bus.wr_b_only));
      pop[c]      = (state == EXEC) && (cnt_a[c] != '0) && (cnt_b[c] != '0);
      head_a[c]   = mem_a[c][rp_a[c]];
      head_b[c]   = mem_b[c][rp_b[c]];
`ifdef MAC_SAT_EN
      sum[c]      = {1'b0, acc[c]} + (ACC_W+1)'(prod[c]);
      nxt_acc[c]  = sum[c][ACC_W] ? '1 : sum[c][ACC_W-1:0];
`else
      nxt_acc[c]  = acc[c] + ACC_W'(prod[c]);
`endif
    end
    wr_fault = bus.wr_en && ((state != IDLE) || (32'(bus.wr_ch) >= N_CH) || (|full_hit));
  end

  // Storage needs no reset: empty counts make stale contents unreachable.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (push_a[c]) mem_a[c][wp_a[c]] <= bus.a_in;
      if (push_b[c]) mem_b[c][wp_b[c]] <= bus.b_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mismatch_q <= '0;
      prod_vld   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        wp_a[c]  <= '0;
        rp_a[c]  <= '0;
        wp_b[c]  <= '0;
        rp_b[c]  <= '0;
        cnt_a[c] <= '0;
        cnt_b[c] <= '0;
        prod[c]  <= '0;
        acc[c]   <= '0;
      end
    end else begin
      if (wr_fault) err_q <= 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        if (push_a[c]) begin
          wp_a[c]  <= wp_a[c] + PW'(1);
          cnt_a[c] <= cnt_a[c] + CW'(1);
        end
        if (push_b[c]) begin
          wp_b[c]  <= wp_b[c] + PW'(1);
          cnt_b[c] <= cnt_b[c] + CW'(1);
        end
        if (pop[c]) begin
          rp_a[c]  <= rp_a[c] + PW'(1);
          rp_b[c]  <= rp_b[c] + PW'(1);
          cnt_a[c] <= cnt_a[c] - CW'(1);
          cnt_b[c] <= cnt_b[c] - CW'(1);
          prod[c]  <= (2*DATA_W)'(head_a[c]) * (2*DATA_W)'(head_b[c]);
        end
        prod_vld[c] <= pop[c];
        if (prod_vld[c]) acc[c] <= nxt_acc[c];
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= EXEC;
            busy_q     <= 1'b1;
            mismatch_q <= '0;
            for (int c = 0; c < N_CH; c++) acc[c] <= '0;
          end
        end
        // Last product is still accumulating on this edge, so exit only needs "no new pops".
        EXEC: begin
          if (pop == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
            for (int c = 0; c < N_CH; c++) begin
              mismatch_q[c] <= (cnt_a[c] != '0) || (cnt_b[c] != '0);
              rp_a[c]       <= wp_a[c];
              rp_b[c]       <= wp_b[c];
              cnt_a[c]      <= '0;
              cnt_b[c]      <= '0;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAC_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= '0;
    end else if ((state == IDLE) && bus.start) begin
      sat_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (prod_vld[c] && sum[c][ACC_W]) sat_q[c] <= 1'b1;
    end
  end
  assign bus.sat = sat_q;
`else
  assign bus.sat = '0;
`endif

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.mismatch = mismatch_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_acc
    assign bus.acc_out[g*ACC_W +: ACC_W] = acc[g];
  end
endmodule
